// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: push-side data, frame configuration and serial/status lines of the UART transmitter.
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE_W = 8
);
    logic [DATA_WIDTH-1:0]         p_data;
    logic                          data_valid;
    logic                          par_en;
    logic                          par_typ;
    logic                          stop2;
    logic [PRESCALE_W-1:0]         prescale;
    logic                          tx_out;
    logic                          busy;
    logic                          ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport master (
        output p_data, data_valid, par_en, par_typ, stop2, prescale,
        input  tx_out, busy, ready, fifo_count
    );
    modport slave (
        input  p_data, data_valid, par_en, par_typ, stop2, prescale,
        output tx_out, busy, ready, fifo_count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small FIFO; frame settings are captured with each popped word.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE_W = 8
) (
    input logic           clk,
    input logic           rst,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state, next;
    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [PRESCALE_W-1:0]  pres_cnt, prescale_l;
    logic [BW-1:0]          bit_cnt;
    logic                   par_en_l, stop2_l, parity_l;
    logic                   tx_d, push, pop, bit_end;

    assign bus.ready      = count != CW'(FIFO_DEPTH);
    assign bus.fifo_count = count;
    assign push           = bus.data_valid && bus.ready;
    assign bit_end        = pres_cnt == prescale_l;

    always_comb begin
        next = state;
        pop  = 1'b0;
        tx_d = 1'b1;
        case (state)
            IDLE: begin
                pop  = count != '0;
                next = pop ? START : IDLE;
            end
            START:  next = bit_end ? DATA : START;
            DATA:   next = (bit_end && bit_cnt == BW'(DATA_WIDTH - 1)) ? (par_en_l ? PARITY : STOP) : DATA;
            PARITY: next = bit_end ? STOP : PARITY;
            STOP: if (bit_end && bit_cnt == BW'(stop2_l)) begin
                // back-to-back frames: pop the next word on the last stop edge
                pop  = count != '0;
                next = pop ? START : IDLE;
            end
            default: next = IDLE;
        endcase
        case (next)
            START:   tx_d = 1'b0;
            DATA:    tx_d = (state == DATA && bit_end) ? shreg[1] : shreg[0];
            PARITY:  tx_d = parity_l;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= bus.p_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pres_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            prescale_l <= '0;
            par_en_l   <= 1'b0;
            stop2_l    <= 1'b0;
            parity_l   <= 1'b0;
            bus.tx_out <= 1'b1;
            bus.busy   <= 1'b0;
        end else begin
            state      <= next;
            bus.tx_out <= tx_d;
            bus.busy   <= next != IDLE;
            pres_cnt   <= (state == IDLE || bit_end) ? '0 : pres_cnt + PRESCALE_W'(1);
            bit_cnt    <= (next != state) ? '0 : bit_end ? bit_cnt + BW'(1) : bit_cnt;
            count      <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                shreg      <= mem[rd_ptr];
                prescale_l <= bus.prescale;
                par_en_l   <= bus.par_en;
                stop2_l    <= bus.stop2;
                parity_l   <= ^mem[rd_ptr] ^ bus.par_typ;
            end else if (state == DATA && bit_end) begin
                shreg <= shreg >> 1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random stimulus checked cycle by cycle against a queue-based line model.
module tb_uart_tx_fifo;
    localparam int DW = 8;
    localparam int FD = 4;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .PRESCALE_W(PW)) bus ();
    uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .PRESCALE_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    bit line_q[$];
    logic [DW-1:0] fifo_q[$];
    logic exp_tx = 1'b1;
    logic exp_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        line_q.delete();
        fifo_q.delete();
        exp_tx = 1'b1;
        exp_busy = 1'b0;
    endfunction

    // expand one word into the per-cycle line values using the settings present at pop time
    function automatic void build(logic [DW-1:0] w);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(w[i]);
        if (bus.par_en) bits.push_back((^w) ^ bus.par_typ);
        bits.push_back(1'b1);
        if (bus.stop2) bits.push_back(1'b1);
        foreach (bits[i])
            for (int r = 0; r <= int'(bus.prescale); r++) line_q.push_back(bits[i]);
    endfunction

    function automatic void model_edge();
        bit rdy;
        if (rst) begin
            model_clear();
            return;
        end
        rdy = fifo_q.size() != FD;
        if (line_q.size() == 0 && fifo_q.size() != 0) build(fifo_q.pop_front());
        if (line_q.size() != 0) begin
            exp_tx = line_q.pop_front();
            exp_busy = 1'b1;
        end else begin
            exp_tx = 1'b1;
            exp_busy = 1'b0;
        end
        if (bus.data_valid && rdy) fifo_q.push_back(bus.p_data);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("tx_out", bus.tx_out, exp_tx);
        chk("busy", bus.busy, exp_busy);
        chk("ready", bus.ready, fifo_q.size() != FD);
        chk("fifo_count", bus.fifo_count, fifo_q.size());
    endtask

    task automatic cfg(input logic pe, input logic pt, input logic s2, input logic [PW-1:0] ps);
        bus.par_en = pe;
        bus.par_typ = pt;
        bus.stop2 = s2;
        bus.prescale = ps;
    endtask

    task automatic push1(input logic [DW-1:0] d);
        bus.p_data = d;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
    endtask

    initial begin
        logic [11:0] seq;
        int busy_n, run, max_run;
        bus.p_data = '0;
        bus.data_valid = 1'b0;
        cfg(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("idle_tx", bus.tx_out, 1'b1);
        chk("idle_count", bus.fifo_count, 0);

        // 9D, odd parity, one stop bit, one cycle per bit
        cfg(1'b1, 1'b1, 1'b0, 8'd0);
        push1(8'h9D);
        seq = '0;
        busy_n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seq = {seq[10:0], bus.tx_out};
            busy_n += int'(bus.busy);
        end
        chk("frame_9d_bits", seq, 12'h5CB);
        chk("frame_9d_busy", busy_n, 11);

        // A5, no parity, two stop bits, four cycles per bit
        cfg(1'b0, 1'b0, 1'b1, 8'd3);
        push1(8'hA5);
        seq = '0;
        busy_n = 0;
        for (int i = 0; i < 46; i++) begin
            tick();
            if (i % 4 == 0 && i < 44) seq = {seq[10:0], bus.tx_out};
            busy_n += int'(bus.busy);
        end
        chk("frame_a5_bits", seq[10:0], 11'h297);
        chk("frame_a5_busy", busy_n, 44);

        // six back-to-back pushes: one in flight, four queued, sixth dropped
        cfg(1'b0, 1'b0, 1'b0, 8'd0);
        run = 0;
        max_run = 0;
        bus.data_valid = 1'b1;
        for (int i = 0; i < 70; i++) begin
            bus.p_data = DW'(8'h30 + i);
            if (i == 6) bus.data_valid = 1'b0;
            tick();
            if (i == 4) chk("full_ready", bus.ready, 1'b0);
            if (i == 5) chk("full_count", bus.fifo_count, FD);
            run = bus.busy ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        chk("b2b_run", max_run, 50);

        // settings changed mid-frame apply only to the next frame
        cfg(1'b1, 1'b0, 1'b0, 8'd1);
        push1(8'h5A);
        for (int i = 0; i < 5; i++) tick();
        cfg(1'b1, 1'b1, 1'b1, 8'd2);
        push1(8'hC3);
        for (int i = 0; i < 60; i++) tick();

        // reset in the middle of DATA with two words queued
        cfg(1'b0, 1'b0, 1'b0, 8'd0);
        bus.data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.p_data = DW'(8'hE0 + i);
            tick();
        end
        bus.data_valid = 1'b0;
        tick();
        chk("pre_rst_count", bus.fifo_count, 2);
        rst = 1'b1;
        #1;
        model_clear();
        chk("rst_tx", bus.tx_out, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_ready", bus.ready, 1'b1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        // first edge after release accepts a push
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push1(8'h11);
        chk("post_rst_busy", bus.busy, 1'b0);
        for (int i = 0; i < 12; i++) tick();

        // random traffic with occasional setting changes
        for (int i = 0; i < 3000; i++) begin
            bus.data_valid = $urandom_range(0, 4) == 0;
            bus.p_data = DW'($urandom);
            if ($urandom_range(0, 40) == 0)
                cfg(1'($urandom), 1'($urandom), 1'($urandom), PW'($urandom_range(0, 3)));
            tick();
        end
        bus.data_valid = 1'b0;
        for (int i = 0; i < 300; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
